niosii_cpu_debug_ocimem: RTL and testbench

- Debug-memory stage directly downstream of the CPU debug-slave wrapper, in the sysclk domain.
- Consumes `jdo` and the one-cycle `take_action_ocimem_*` pulses, and executes them against a single-port on-chip debug RAM.
- Returns read data on `MonDReg` and monitor status on `monitor_ready`/`monitor_error`; these feed back into the debug-slave TCK capture path.
- Also exposes an Avalon-MM slave so the CPU's debug monitor code can share the same RAM and status register.

---
 rtl/niosii_cpu_debug_ocimem.sv | 217 +++++++++++++++++++++
 tb/tb_niosii_cpu_debug_ocimem.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/niosii_cpu_debug_ocimem.sv
// Debug-memory stage of the Nios II CPU debug block.
// Executes JTAG take_action_ocimem_* commands against a single-port debug
// RAM with registered output, and shares that RAM plus a two-bit monitor
// status register with the CPU through an Avalon-MM slave. A JTAG command
// always owns the RAM port in its cycle; a CPU access that meets a JTAG
// command is stalled and retried by the master.
module niosii_cpu_debug_ocimem #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              debugack,
    input  logic [ADDR_W:0]   avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } cpu_state_e;

    // State
    cpu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] mon_a_q, mon_a_d;
    logic [31:0]       mon_d_q, mon_d_d;
    logic              rd_pend_q, rd_pend_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic              cpu_ctrl_q, cpu_ctrl_d;
    logic [31:0]       ram_q_q;

    logic [31:0]       mem [0:DEPTH-1];

    // Decoded commands and RAM port controls
    logic              act_a_s, act_b_s, act_na_s, pulse_any_s;
    logic              cpu_req_s, cpu_rd_s, cpu_wr_s, cpu_ctrl_sel_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic              ram_re_s, ram_we_s;
    logic [3:0]        ram_be_s;
    logic [31:0]       ram_wdata_s;

    // Bits of jdo that this stage never looks at
    logic              unused_jdo_s;
    assign unused_jdo_s = ^{jdo[37:36], jdo[1:0]};

    // JTAG command priority (a > b > no_action_a) and CPU request qualification
    always_comb begin
        pulse_any_s    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
        act_a_s        = take_action_ocimem_a;
        act_b_s        = ~take_action_ocimem_a & take_action_ocimem_b;
        act_na_s       = ~take_action_ocimem_a & ~take_action_ocimem_b & take_no_action_ocimem_a;
        cpu_req_s      = (state_q == ST_IDLE) & (avs_read | avs_write) & ~pulse_any_s;
        cpu_rd_s       = cpu_req_s & avs_read;
        cpu_wr_s       = cpu_req_s & ~avs_read & avs_write;
        cpu_ctrl_sel_s = avs_address[ADDR_W];
    end

    // RAM port arbitration: a JTAG command owns the port, otherwise the CPU
    always_comb begin
        ram_addr_s  = mon_a_q;
        ram_re_s    = 1'b0;
        ram_we_s    = 1'b0;
        ram_be_s    = 4'b0000;
        ram_wdata_s = 32'h0000_0000;
        if (act_a_s) begin
            ram_addr_s = jdo[ADDR_W+1:2];
            ram_re_s   = jdo[35];
        end else if (act_b_s) begin
            ram_addr_s  = mon_a_q;
            ram_we_s    = debugack;
            ram_be_s    = 4'b1111;
            ram_wdata_s = jdo[34:3];
        end else if (act_na_s) begin
            ram_addr_s = mon_a_q;
            ram_re_s   = 1'b1;
        end else if ((cpu_rd_s | cpu_wr_s) & ~cpu_ctrl_sel_s) begin
            ram_addr_s  = avs_address[ADDR_W-1:0];
            ram_re_s    = cpu_rd_s;
            ram_we_s    = cpu_wr_s;
            ram_be_s    = avs_byteenable;
            ram_wdata_s = avs_writedata;
        end else begin
            ram_re_s = 1'b0;
        end
    end

    // JTAG address/data registers and read pipeline
    always_comb begin
        mon_a_d   = mon_a_q;
        mon_d_d   = mon_d_q;
        rd_pend_d = (act_a_s & jdo[35]) | act_na_s;
        if (act_a_s) begin
            mon_a_d = jdo[ADDR_W+1:2];
        end else if ((act_b_s & debugack) | act_na_s) begin
            mon_a_d = mon_a_q + ADDR_ONE;
        end else begin
            mon_a_d = mon_a_q;
        end
        if (rd_pend_q) begin
            mon_d_d = ram_q_q;
        end else begin
            mon_d_d = mon_d_q;
        end
    end

    // Monitor flags: JTAG clear, CPU control-register set
    always_comb begin
        ready_d = ready_q;
        error_d = error_q;
        if (act_a_s & jdo[34]) begin
            ready_d = 1'b0;
            error_d = 1'b0;
        end else if (cpu_wr_s & cpu_ctrl_sel_s) begin
            if (avs_writedata[0]) begin
                ready_d = 1'b1;
            end else begin
                ready_d = ready_q;
            end
            if (avs_writedata[1]) begin
                error_d = 1'b1;
            end else begin
                error_d = error_q;
            end
        end else begin
            ready_d = ready_q;
        end
    end

    // CPU slave FSM: next state, waitrequest and read data
    always_comb begin
        state_d         = state_q;
        avs_waitrequest = 1'b0;
        avs_readdata    = 32'h0000_0000;
        cpu_ctrl_d      = cpu_rd_s ? cpu_ctrl_sel_s : cpu_ctrl_q;
        case (state_q)
            ST_IDLE: begin
                if ((avs_read | avs_write) & pulse_any_s) begin
                    avs_waitrequest = 1'b1;
                end else if (avs_read) begin
                    avs_waitrequest = 1'b1;
                    state_d         = ST_RD_WAIT;
                end else begin
                    avs_waitrequest = 1'b0;
                end
            end
            ST_RD_WAIT: begin
                avs_waitrequest = 1'b0;
                avs_readdata    = cpu_ctrl_q ? {30'b0, error_q, ready_q} : ram_q_q;
                state_d         = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            mon_a_q    <= '0;
            mon_d_q    <= 32'h0000_0000;
            rd_pend_q  <= 1'b0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            cpu_ctrl_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mon_a_q    <= mon_a_d;
            mon_d_q    <= mon_d_d;
            rd_pend_q  <= rd_pend_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
            cpu_ctrl_q <= cpu_ctrl_d;
        end
    end

    // RAM registered read port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_q_q <= 32'h0000_0000;
        end else if (ram_re_s) begin
            ram_q_q <= mem[ram_addr_s];
        end
    end

    // RAM array with byte-lane writes; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be_s[i]) begin
                    mem[ram_addr_s][i*8 +: 8] <= ram_wdata_s[i*8 +: 8];
                end
            end
        end
    end

    assign MonDReg       = mon_d_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;

endmodule

// File: tb/tb_niosii_cpu_debug_ocimem.sv
// Directed bench for niosii_cpu_debug_ocimem: JTAG read expectations go
// through a scoreboard queue, everything else is compared immediately.
module tb_niosii_cpu_debug_ocimem;

    logic        clk;
    logic        reset_n;
    logic [37:0] jdo;
    logic        tk_a, tk_b, tk_na;
    logic        debugack;
    logic [8:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    niosii_cpu_debug_ocimem #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (tk_a),
        .take_action_ocimem_b    (tk_b),
        .take_no_action_ocimem_a (tk_na),
        .debugack                (debugack),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [37:0] jd_addr(input logic rd, input logic clr, input logic [7:0] a);
        logic [37:0] v;
        v       = 38'h0;
        v[35]   = rd;
        v[34]   = clr;
        v[9:2]  = a;
        return v;
    endfunction

    function automatic logic [37:0] jd_data(input logic [31:0] d);
        logic [37:0] v;
        v       = 38'h0;
        v[34:3] = d;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $error("FAIL %s: observed empty-scoreboard expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, MonDReg, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic rd, input logic clr, input logic [7:0] a);
        jdo  = jd_addr(rd, clr, a);
        tk_a = 1'b1;
        tick();
        tk_a = 1'b0;
    endtask

    task automatic pulse_b(input logic [31:0] d);
        jdo  = jd_data(d);
        tk_b = 1'b1;
        tick();
        tk_b = 1'b0;
    endtask

    // JTAG read through the address-load path; result lands two edges later
    task automatic jtag_read(input logic [7:0] a, input logic [31:0] e, input string tag);
        pulse_a(1'b1, 1'b0, a);
        exp_q.push_back(e);
        tick();
        pop_chk(tag);
    endtask

    initial begin
        reset_n = 1'b0; jdo = 38'h0; tk_a = 1'b0; tk_b = 1'b0; tk_na = 1'b0;
        debugack = 1'b1; avs_address = 9'h000; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = 32'h0; avs_byteenable = 4'h0;
        tick(); tick();
        chk("rst_mondreg", MonDReg, 32'h0);
        chk("rst_flags", {30'b0, monitor_error, monitor_ready}, 32'h0);
        chk("rst_wait", {31'b0, avs_waitrequest}, 32'h0);
        chk("rst_rdata", avs_readdata, 32'h0);
        chk("rst_mona", {24'h0, dut.mon_a_q}, 32'h0);
        reset_n = 1'b1;
        tick();

        // address load without read, then write-and-increment
        pulse_a(1'b0, 1'b0, 8'h10);
        chk("load_mona", {24'h0, dut.mon_a_q}, 32'h10);
        tick();
        chk("load_noread", MonDReg, 32'h0);
        pulse_b(32'hDEADBEEF);
        chk("wr_inc", {24'h0, dut.mon_a_q}, 32'h11);
        pulse_b(32'hCAFEF00D);

        // read via address load: not visible after one edge, visible after two
        pulse_a(1'b1, 1'b0, 8'h10);
        exp_q.push_back(32'hDEADBEEF);
        chk("rd_latency", MonDReg, 32'h0);
        chk("rd_noinc", {24'h0, dut.mon_a_q}, 32'h10);
        tick();
        pop_chk("rd_a");

        // back-to-back read-and-increment
        tk_na = 1'b1;
        exp_q.push_back(32'hDEADBEEF);
        tick();
        exp_q.push_back(32'hCAFEF00D);
        tick();
        tk_na = 1'b0;
        pop_chk("rd_na0");
        tick();
        pop_chk("rd_na1");
        chk("na_mona", {24'h0, dut.mon_a_q}, 32'h12);

        // wrap of the address register
        pulse_a(1'b0, 1'b0, 8'hFF);
        pulse_b(32'h0BADF00D);
        chk("wrap_b", {24'h0, dut.mon_a_q}, 32'h0);
        pulse_a(1'b0, 1'b0, 8'hFF);
        tk_na = 1'b1;
        exp_q.push_back(32'h0BADF00D);
        tick();
        tk_na = 1'b0;
        tick();
        pop_chk("rd_ff");
        chk("wrap_na", {24'h0, dut.mon_a_q}, 32'h0);

        // priority: a wins over b in the same cycle
        jdo = jd_addr(1'b0, 1'b0, 8'h30);
        tk_a = 1'b1; tk_b = 1'b1;
        tick();
        tk_a = 1'b0; tk_b = 1'b0;
        chk("prio_ab", {24'h0, dut.mon_a_q}, 32'h30);

        // writes ignored outside debug mode
        debugack = 1'b0;
        pulse_a(1'b0, 1'b0, 8'h10);
        pulse_b(32'h11111111);
        chk("nodbg_mona", {24'h0, dut.mon_a_q}, 32'h10);
        debugack = 1'b1;
        jtag_read(8'h10, 32'hDEADBEEF, "nodbg_ram");

        // CPU control-register write and read
        avs_address = 9'h100; avs_writedata = 32'h3; avs_byteenable = 4'hF; avs_write = 1'b1;
        #1;
        chk("cw_wait", {31'b0, avs_waitrequest}, 32'h0);
        tick();
        avs_write = 1'b0;
        chk("cw_flags", {30'b0, monitor_error, monitor_ready}, 32'h3);
        avs_read = 1'b1;
        #1;
        chk("cr_wait1", {31'b0, avs_waitrequest}, 32'h1);
        chk("cr_rdata0", avs_readdata, 32'h0);
        tick();
        chk("cr_wait0", {31'b0, avs_waitrequest}, 32'h0);
        chk("cr_rdata", avs_readdata, 32'h3);
        avs_read = 1'b0;
        tick();
        chk("cr_idle", avs_readdata, 32'h0);
        pulse_a(1'b0, 1'b1, 8'h10);
        chk("clr_flags", {30'b0, monitor_error, monitor_ready}, 32'h0);

        // CPU byte write colliding with a JTAG pulse, then retried
        pulse_a(1'b0, 1'b0, 8'h20);
        pulse_b(32'hAABBCCDD);
        avs_address = 9'h020; avs_writedata = 32'h12345678; avs_byteenable = 4'b0011; avs_write = 1'b1;
        jdo = jd_addr(1'b0, 1'b0, 8'h10);
        tk_a = 1'b1;
        #1;
        chk("coll_wait", {31'b0, avs_waitrequest}, 32'h1);
        tick();
        tk_a = 1'b0;
        #1;
        chk("retry_wait", {31'b0, avs_waitrequest}, 32'h0);
        tick();
        avs_write = 1'b0;
        avs_read = 1'b1;
        tick();
        chk("cpu_rd_ram", avs_readdata, 32'hAABB5678);
        avs_read = 1'b0;
        tick();
        jtag_read(8'h20, 32'hAABB5678, "be_ram");

        // reset with a CPU read in flight
        avs_address = 9'h100; avs_writedata = 32'h3; avs_byteenable = 4'hF; avs_write = 1'b1;
        tick();
        avs_write = 1'b0;
        avs_address = 9'h010; avs_read = 1'b1;
        tick();
        reset_n = 1'b0;
        #1;
        chk("rst2_rdata", avs_readdata, 32'h0);
        chk("rst2_mondreg", MonDReg, 32'h0);
        chk("rst2_flags", {30'b0, monitor_error, monitor_ready}, 32'h0);
        avs_read = 1'b0;
        #1;
        chk("rst2_wait", {31'b0, avs_waitrequest}, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst2_idle", avs_readdata, 32'h0);
        jtag_read(8'h10, 32'hDEADBEEF, "keep_10");
        jtag_read(8'h20, 32'hAABB5678, "keep_20");

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
